// File: rtl/zebra_pkg.sv
// Shared types and width helpers for the zebra-crossing stripe scanner.
package zebra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLUSH,
        ROW_END,
        DONE
    } state_e;

    localparam int STRIPE_W = 8;
    localparam logic [STRIPE_W-1:0] STRIPE_MAX = {STRIPE_W{1'b1}};

    function automatic int addr_width(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction

    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/zebra_run_classifier.sv
// Measures white runs on one scanline and counts those whose length qualifies as a stripe.
module zebra_run_classifier
    import zebra_pkg::*;
#(
    parameter int MIN_RUN = 8,
    parameter int MAX_RUN = 160
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                pixel_i,
    input  logic                last_i,
    input  logic                clear_i,
    output logic [STRIPE_W-1:0] row_stripes_o
);

    localparam int RUN_W = $clog2(MAX_RUN + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] MIN_L   = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0] MAX_L   = RUN_W'(MAX_RUN);

    logic [RUN_W-1:0]    run_q, run_d, run_inc, close_len;
    logic [STRIPE_W-1:0] stripes_q, stripes_d;
    logic                close_run, is_stripe;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        run_inc   = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
        run_d     = run_q;
        stripes_d = stripes_q;
        close_run = 1'b0;
        close_len = run_q;

        if (valid_i) begin
            if (pixel_i) begin
                run_d = run_inc;
                if (last_i) begin
                    close_run = 1'b1;
                    close_len = run_inc;
                    run_d     = '0;
                end
            end else begin
                close_run = 1'b1;
                run_d     = '0;
            end
        end

        // A zero-length "run" is just consecutive black pixels and never counts.
        is_stripe = close_run && (close_len != '0) &&
                    (close_len >= MIN_L) && (close_len <= MAX_L);
        if (is_stripe && (stripes_q != STRIPE_MAX)) begin
            stripes_d = stripes_q + STRIPE_W'(1);
        end

        if (clear_i) begin
            run_d     = '0;
            stripes_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= '0;
            stripes_q <= '0;
        end else begin
            run_q     <= run_d;
            stripes_q <= stripes_d;
        end
    end

    assign row_stripes_o = stripes_q;

endmodule

// File: rtl/zebra_stripe_scanner.sv
// Scans a fixed set of image rows from BRAM, counts stripe-like white runs and votes on a crossing.
module zebra_stripe_scanner
    import zebra_pkg::*;
#(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int NUM_SCANLINES = 8,
    parameter int ROW_START     = 240,
    parameter int ROW_STEP      = 24,
    parameter int MIN_RUN       = 8,
    parameter int MAX_RUN       = 160,
    parameter int MIN_STRIPES   = 3,
    parameter int MIN_VOTES     = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            crossing_detected,
    output logic [STRIPE_W-1:0]                             stripe_count,
    output logic [count_width(NUM_SCANLINES)-1:0]           vote_count,
    output logic [addr_width(IMG_WIDTH, IMG_HEIGHT)-1:0]    pixel_addr,
    input  logic                                            pixel_data
);

    localparam int ADDR_W = addr_width(IMG_WIDTH, IMG_HEIGHT);
    localparam int VOTE_W = count_width(NUM_SCANLINES);
    localparam int ROW_W  = count_width(NUM_SCANLINES);
    localparam int X_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [X_W-1:0]      X_LAST      = X_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(NUM_SCANLINES - 1);
    localparam logic [STRIPE_W-1:0] MIN_STR_L   = STRIPE_W'(MIN_STRIPES);
    localparam logic [VOTE_W-1:0]   MIN_VOTES_L = VOTE_W'(MIN_VOTES);

    if (ROW_START + (NUM_SCANLINES - 1) * ROW_STEP >= IMG_HEIGHT) begin : g_bad_rows
        $error("zebra_stripe_scanner: last scanline lies at or beyond IMG_HEIGHT");
    end
    if (MIN_RUN > MAX_RUN) begin : g_bad_runs
        $error("zebra_stripe_scanner: MIN_RUN exceeds MAX_RUN");
    end

    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] k);
        return ADDR_W'((ROW_START + int'(k) * ROW_STEP) * IMG_WIDTH);
    endfunction

    state_e              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [VOTE_W-1:0]   vote_q, vote_d;
    logic [STRIPE_W-1:0] stripe_q, stripe_d;
    logic                det_q, det_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                frame_start;
    logic                pix_valid, pix_last, cls_clear;
    logic [STRIPE_W-1:0] row_stripes;

    // Pixel data lags the address by one cycle, so SCAN x=0 has nothing to process yet.
    assign pix_valid = ((state_q == SCAN) && (x_q != '0)) || (state_q == FLUSH);
    assign pix_last  = (state_q == FLUSH);
    assign cls_clear = (state_q == ROW_END) || frame_start;

    zebra_run_classifier #(
        .MIN_RUN (MIN_RUN),
        .MAX_RUN (MAX_RUN)
    ) u_classifier (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (pix_valid),
        .pixel_i       (pixel_data),
        .last_i        (pix_last),
        .clear_i       (cls_clear),
        .row_stripes_o (row_stripes)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        row_d       = row_q;
        addr_d      = addr_q;
        vote_d      = vote_q;
        stripe_d    = stripe_q;
        det_d       = det_q;
        done_d      = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_start = 1'b1;
                    state_d     = SCAN;
                    x_d         = '0;
                    row_d       = '0;
                    addr_d      = row_base('0);
                    vote_d      = '0;
                    stripe_d    = '0;
                    det_d       = 1'b0;
                end
            end
            SCAN: begin
                if (x_q == X_LAST) begin
                    state_d = FLUSH;
                end else begin
                    x_d    = x_q + X_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            FLUSH: state_d = ROW_END;
            ROW_END: begin
                if (row_stripes >= MIN_STR_L) begin
                    vote_d = vote_q + VOTE_W'(1);
                end
                if (row_stripes > stripe_q) begin
                    stripe_d = row_stripes;
                end
                if (row_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                    row_d   = row_q + ROW_W'(1);
                    x_d     = '0;
                    addr_d  = row_base(row_q + ROW_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                det_d   = (vote_q >= MIN_VOTES_L);
            end
            default: state_d = IDLE;
        endcase

        // busy stays up through DONE and drops on the edge that raises the done pulse.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            vote_q   <= '0;
            stripe_q <= '0;
            det_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            vote_q   <= vote_d;
            stripe_q <= stripe_d;
            det_q    <= det_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign crossing_detected = det_q;
    assign stripe_count      = stripe_q;
    assign vote_count        = vote_q;
    assign pixel_addr        = addr_q;

endmodule

// File: tb/tb_zebra_stripe_scanner.sv
// Directed and randomised frame scans compared against a run-length reference model.
module tb_zebra_stripe_scanner;

    localparam int W     = 64;
    localparam int H     = 16;
    localparam int NS    = 4;
    localparam int RS    = 2;
    localparam int RSTEP = 4;
    localparam int MINR  = 4;
    localparam int MAXR  = 16;
    localparam int MINS  = 3;
    localparam int MINV  = 2;
    localparam int LAT   = NS * (W + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pixel_data = 1'b0;
    logic       busy, done, crossing_detected;
    logic [7:0] stripe_count;
    logic [2:0] vote_count;
    logic [9:0] pixel_addr;

    bit img [W*H];
    int n_checks = 0;
    int n_err    = 0;

    zebra_stripe_scanner #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .NUM_SCANLINES (NS),
        .ROW_START     (RS),
        .ROW_STEP      (RSTEP),
        .MIN_RUN       (MINR),
        .MAX_RUN       (MAXR),
        .MIN_STRIPES   (MINS),
        .MIN_VOTES     (MINV)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .crossing_detected (crossing_detected),
        .stripe_count      (stripe_count),
        .vote_count        (vote_count),
        .pixel_addr        (pixel_addr),
        .pixel_data        (pixel_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pixel_data <= img[int'(pixel_addr)];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int row_of(input int k);
        return RS + k * RSTEP;
    endfunction

    task automatic fill_img(input bit v);
        for (int i = 0; i < W * H; i++) img[i] = v;
    endtask

    task automatic paint(input int y, input int x0, input int w);
        for (int x = x0; x < x0 + w; x++) if (x < W) img[y * W + x] = 1'b1;
    endtask

    task automatic zebra_img();
        fill_img(1'b0);
        for (int k = 0; k < NS; k++)
            for (int s = 0; s < 4; s++) paint(row_of(k), s * 16, 8);
    endtask

    // Reference: walk each scanline, measure true run lengths, apply the stripe/vote rules.
    task automatic model(output int sc, output int vc, output int det);
        sc = 0;
        vc = 0;
        for (int k = 0; k < NS; k++) begin
            int rs;
            int len;
            rs  = 0;
            len = 0;
            for (int x = 0; x <= W; x++) begin
                if (x < W && img[row_of(k) * W + x]) begin
                    len++;
                end else begin
                    if (len >= MINR && len <= MAXR) rs++;
                    len = 0;
                end
            end
            if (rs > 255) rs = 255;
            if (rs >= MINS) vc++;
            if (rs > sc) sc = rs;
        end
        det = (vc >= MINV) ? 1 : 0;
    endtask

    task automatic run_frame(input string tag, input bit hold);
        int cyc, extra, exp_sc, exp_vc, exp_det;
        bit busy_drop;
        model(exp_sc, exp_vc, exp_det);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check({tag, ".busy_rise"}, busy, 1);
        cyc       = 0;
        busy_drop = 1'b0;
        while (!done && cyc < 4 * LAT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && !busy) busy_drop = 1'b1;
        end
        start = 1'b0;
        check({tag, ".latency"}, cyc, LAT);
        check({tag, ".busy_held"}, busy_drop, 0);
        check({tag, ".stripe_count"}, stripe_count, exp_sc);
        check({tag, ".vote_count"}, vote_count, exp_vc);
        check({tag, ".crossing"}, crossing_detected, exp_det);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".addr_hold"}, pixel_addr, row_of(NS - 1) * W + W - 1);
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check({tag, ".single_done"}, extra, 0);
        check({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        fill_img(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.crossing", crossing_detected, 0);
        check("rst.stripe_count", stripe_count, 0);
        check("rst.vote_count", vote_count, 0);
        check("rst.pixel_addr", pixel_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        zebra_img();
        run_frame("zebra", 1'b0);
        check("zebra.const_sc", stripe_count, 4);
        check("zebra.const_vc", vote_count, 4);
        check("zebra.const_det", crossing_detected, 1);

        fill_img(1'b0);
        run_frame("black", 1'b0);
        check("black.const_vc", vote_count, 0);

        fill_img(1'b1);
        run_frame("white", 1'b0);
        check("white.const_sc", stripe_count, 0);

        fill_img(1'b0);
        for (int k = 0; k < NS; k++) begin
            paint(row_of(k), 0, 3);
            paint(row_of(k), 5, 4);
            paint(row_of(k), 11, 16);
            paint(row_of(k), 29, 17);
            paint(row_of(k), 56, 8);
        end
        run_frame("bounds", 1'b0);
        check("bounds.const_sc", stripe_count, 3);

        fill_img(1'b0);
        for (int s = 0; s < 4; s++) paint(row_of(0), s * 16, 8);
        run_frame("one_row", 1'b0);
        check("one_row.const_sc", stripe_count, 4);
        check("one_row.const_vc", vote_count, 1);
        check("one_row.const_det", crossing_detected, 0);

        zebra_img();
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        seen_done = 1'b0;
        repeat (98) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.vote_count", vote_count, 0);
        check("abort.pixel_addr", pixel_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        if (done) seen_done = 1'b1;
        rst = 1'b0;
        check("abort.no_done", seen_done, 0);
        run_frame("rerun", 1'b0);
        check("rerun.const_vc", vote_count, 4);

        run_frame("held_start", 1'b1);

        for (int f = 0; f < 4; f++) begin
            fill_img(1'b0);
            for (int k = 0; k < NS; k++) begin
                int x;
                if ($urandom_range(0, 4) == 0) continue;
                x = int'($urandom_range(0, 3));
                while (x < W) begin
                    int w;
                    w = int'($urandom_range(1, 20));
                    paint(row_of(k), x, w);
                    x += w + int'($urandom_range(1, 6));
                end
            end
            run_frame($sformatf("rand%0d", f), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
